// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station with tag wakeup and one issue per cycle.
// Define RS_AGE_PRIO_EN to select the oldest ready entry instead of the lowest index.
module rs_alu #(
`ifdef RS_AGE_PRIO_EN
    parameter int AGE_W = 4,
`endif
    parameter int ROB_WIDTH = 4,
    parameter int RS_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,
    input  logic                 issue_valid,
    input  logic [3:0]           issue_opcode,
    input  logic [31:0]          issue_vj,
    input  logic [ROB_WIDTH-1:0] issue_qj,
    input  logic                 issue_qj_valid,
    input  logic [31:0]          issue_vk,
    input  logic [ROB_WIDTH-1:0] issue_qk,
    input  logic                 issue_qk_valid,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 rs_full,
    input  logic                 alu_done,
    input  logic [31:0]          alu_value,
    input  logic [ROB_WIDTH-1:0] alu_tag,
    input  logic                 lsb_done,
    input  logic [31:0]          lsb_value,
    input  logic [ROB_WIDTH-1:0] lsb_tag,
    output logic                 cal_signal,
    output logic [3:0]           opcode,
    output logic [31:0]          lhs,
    output logic [31:0]          rhs,
    output logic [ROB_WIDTH-1:0] tag
);
    localparam int RS_SIZE = 1 << RS_WIDTH;

    logic [RS_SIZE-1:0]                valid, qj_valid, qk_valid;
    logic [RS_SIZE-1:0][3:0]           e_op;
    logic [RS_SIZE-1:0][31:0]          e_vj, e_vk;
    logic [RS_SIZE-1:0][ROB_WIDTH-1:0] e_qj, e_qk, e_tag;
`ifdef RS_AGE_PRIO_EN
    logic [RS_SIZE-1:0][AGE_W-1:0]     age;
`endif
    logic [RS_WIDTH:0]   count;
    logic [RS_WIDTH-1:0] free_idx, sel_idx;
    logic                sel_found, dispatch;
    logic                dj_alu, dj_lsb, dk_alu, dk_lsb;

    assign rs_full  = count == (RS_WIDTH+1)'(RS_SIZE);
    assign dispatch = issue_valid && !rs_full;
    assign dj_alu   = issue_qj_valid && alu_done && issue_qj == alu_tag;
    assign dj_lsb   = issue_qj_valid && lsb_done && issue_qj == lsb_tag;
    assign dk_alu   = issue_qk_valid && alu_done && issue_qk == alu_tag;
    assign dk_lsb   = issue_qk_valid && lsb_done && issue_qk == lsb_tag;

    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!valid[i]) free_idx = RS_WIDTH'(i);
    end

    // Readiness is taken from registered state only, so a same-cycle wakeup waits one cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++)
`ifdef RS_AGE_PRIO_EN
            if (valid[i] && !qj_valid[i] && !qk_valid[i] && (!sel_found || age[i] > age[sel_idx])) begin
`else
            if (valid[i] && !qj_valid[i] && !qk_valid[i] && !sel_found) begin
`endif
                sel_found = 1'b1;
                sel_idx   = RS_WIDTH'(i);
            end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid      <= '0;
            qj_valid   <= '0;
            qk_valid   <= '0;
            e_op       <= '0;
            e_vj       <= '0;
            e_vk       <= '0;
            e_qj       <= '0;
            e_qk       <= '0;
            e_tag      <= '0;
`ifdef RS_AGE_PRIO_EN
            age        <= '0;
`endif
            count      <= '0;
            cal_signal <= 1'b0;
            opcode     <= '0;
            lhs        <= '0;
            rhs        <= '0;
            tag        <= '0;
        end else if (rdy_in) begin
            if (clear_signal) begin
                valid      <= '0;
                count      <= '0;
                cal_signal <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (valid[i] && qj_valid[i] && alu_done && e_qj[i] == alu_tag) begin
                        qj_valid[i] <= 1'b0;
                        e_vj[i]     <= alu_value;
                    end else if (valid[i] && qj_valid[i] && lsb_done && e_qj[i] == lsb_tag) begin
                        qj_valid[i] <= 1'b0;
                        e_vj[i]     <= lsb_value;
                    end
                    if (valid[i] && qk_valid[i] && alu_done && e_qk[i] == alu_tag) begin
                        qk_valid[i] <= 1'b0;
                        e_vk[i]     <= alu_value;
                    end else if (valid[i] && qk_valid[i] && lsb_done && e_qk[i] == lsb_tag) begin
                        qk_valid[i] <= 1'b0;
                        e_vk[i]     <= lsb_value;
                    end
`ifdef RS_AGE_PRIO_EN
                    if (age[i] != '1) age[i] <= age[i] + 1'b1;
`endif
                end
                cal_signal <= sel_found;
                if (sel_found) begin
                    valid[sel_idx] <= 1'b0;
                    opcode         <= e_op[sel_idx];
                    lhs            <= e_vj[sel_idx];
                    rhs            <= e_vk[sel_idx];
                    tag            <= e_tag[sel_idx];
                end
                // The free slot comes from registered valid bits, so the winner's slot is never reused this cycle.
                if (dispatch) begin
                    valid[free_idx]    <= 1'b1;
                    e_op[free_idx]     <= issue_opcode;
                    e_tag[free_idx]    <= issue_tag;
                    e_qj[free_idx]     <= issue_qj;
                    e_qk[free_idx]     <= issue_qk;
                    qj_valid[free_idx] <= issue_qj_valid && !dj_alu && !dj_lsb;
                    qk_valid[free_idx] <= issue_qk_valid && !dk_alu && !dk_lsb;
                    e_vj[free_idx]     <= dj_alu ? alu_value : dj_lsb ? lsb_value : issue_vj;
                    e_vk[free_idx]     <= dk_alu ? alu_value : dk_lsb ? lsb_value : issue_vk;
`ifdef RS_AGE_PRIO_EN
                    age[free_idx]      <= '0;
`endif
                end
                count <= count + (RS_WIDTH+1)'(dispatch) - (RS_WIDTH+1)'(sel_found);
            end
        end
    end
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed scenarios plus randomized traffic checked against a behavioural reservation-station model.
module tb_rs_alu;
    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, clear_signal = 1'b0;
    logic        issue_valid = 1'b0, issue_qj_valid = 1'b0, issue_qk_valid = 1'b0;
    logic [3:0]  issue_opcode = '0, issue_qj = '0, issue_qk = '0, issue_tag = '0;
    logic [31:0] issue_vj = '0, issue_vk = '0;
    logic        alu_done = 1'b0, lsb_done = 1'b0;
    logic [31:0] alu_value = '0, lsb_value = '0;
    logic [3:0]  alu_tag = '0, lsb_tag = '0;
    logic        rs_full, cal_signal;
    logic [3:0]  opcode, tag;
    logic [31:0] lhs, rhs;

    rs_alu dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_qj_valid(issue_qj_valid),
        .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_qk_valid(issue_qk_valid),
        .issue_tag(issue_tag), .rs_full(rs_full),
        .alu_done(alu_done), .alu_value(alu_value), .alu_tag(alu_tag),
        .lsb_done(lsb_done), .lsb_value(lsb_value), .lsb_tag(lsb_tag),
        .cal_signal(cal_signal), .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        v;
        logic [3:0]  op, qj, qk, tg;
        logic [31:0] vj, vk;
        logic        jw, kw;
        int          age;
    } ent_t;

    ent_t        m [8];
    ent_t        n [8];
    logic        m_cal, n_cal;
    logic [3:0]  m_opc, n_opc, m_tg, n_tg;
    logic [31:0] m_lhs, n_lhs, m_rhs, n_rhs;
    int          passed = 0, total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) if (m[i].v) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = '{default: 0};
        m_cal = 0; m_opc = 0; m_tg = 0; m_lhs = 0; m_rhs = 0;
    endtask

    // Next state from the current model state and the inputs presented before the edge.
    task automatic model_step();
        int win = -1;
        int f = -1;
        ent_t e;
        n = m; n_cal = m_cal; n_opc = m_opc; n_tg = m_tg; n_lhs = m_lhs; n_rhs = m_rhs;
        if (!rdy_in) return;
        if (clear_signal) begin
            for (int i = 0; i < 8; i++) n[i].v = 0;
            n_cal = 0;
            return;
        end
        for (int i = 0; i < 8; i++)
            if (m[i].v && !m[i].jw && !m[i].kw)
`ifdef RS_AGE_PRIO_EN
                if (win < 0 || m[i].age > m[win].age) win = i;
`else
                if (win < 0) win = i;
`endif
        n_cal = win >= 0;
        if (win >= 0) begin
            n_opc = m[win].op; n_lhs = m[win].vj; n_rhs = m[win].vk; n_tg = m[win].tg;
        end
        for (int i = 0; i < 8; i++) begin
            if (m[i].v && m[i].jw && alu_done && m[i].qj == alu_tag) begin n[i].jw = 0; n[i].vj = alu_value; end
            else if (m[i].v && m[i].jw && lsb_done && m[i].qj == lsb_tag) begin n[i].jw = 0; n[i].vj = lsb_value; end
            if (m[i].v && m[i].kw && alu_done && m[i].qk == alu_tag) begin n[i].kw = 0; n[i].vk = alu_value; end
            else if (m[i].v && m[i].kw && lsb_done && m[i].qk == lsb_tag) begin n[i].kw = 0; n[i].vk = lsb_value; end
            if (n[i].age < 15) n[i].age++;
        end
        if (win >= 0) n[win].v = 0;
        if (issue_valid && m_count() < 8) begin
            for (int i = 7; i >= 0; i--) if (!m[i].v) f = i;
            e = '{v: 1, op: issue_opcode, qj: issue_qj, qk: issue_qk, tg: issue_tag,
                  vj: issue_vj, vk: issue_vk, jw: issue_qj_valid, kw: issue_qk_valid, age: 0};
            if (e.jw && alu_done && e.qj == alu_tag) begin e.jw = 0; e.vj = alu_value; end
            else if (e.jw && lsb_done && e.qj == lsb_tag) begin e.jw = 0; e.vj = lsb_value; end
            if (e.kw && alu_done && e.qk == alu_tag) begin e.kw = 0; e.vk = alu_value; end
            else if (e.kw && lsb_done && e.qk == lsb_tag) begin e.kw = 0; e.vk = lsb_value; end
            n[f] = e;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
        m = n; m_cal = n_cal; m_opc = n_opc; m_tg = n_tg; m_lhs = n_lhs; m_rhs = n_rhs;
    endtask

    task automatic idle();
        rdy_in = 1; clear_signal = 0; issue_valid = 0; alu_done = 0; lsb_done = 0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] vj, input logic jw, input logic [3:0] qj,
                        input logic [31:0] vk, input logic kw, input logic [3:0] qk, input logic [3:0] tg);
        issue_valid = 1; issue_opcode = op; issue_vj = vj; issue_qj_valid = jw; issue_qj = qj;
        issue_vk = vk; issue_qk_valid = kw; issue_qk = qk; issue_tag = tg;
    endtask

    always @(negedge clk_in)
        if (!rst_in) begin
            chk("cal_signal", cal_signal, m_cal);
            chk("opcode", opcode, m_opc);
            chk("lhs", lhs, m_lhs);
            chk("rhs", rhs, m_rhs);
            chk("tag", tag, m_tg);
            chk("rs_full", rs_full, m_count() == 8);
        end

    initial begin
        model_reset();
        idle();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 0;
        chk("reset cal", cal_signal, 0);
        chk("reset lhs", lhs, 0);
        chk("reset full", rs_full, 0);

        // mid-run reset with three waiting entries and an issue in flight
        for (int i = 0; i < 3; i++) begin
            disp(4'd1, 0, 1, 4'd12, 0, 0, 0, 4'(i)); tick();
        end
        disp(4'd4, 32'h1, 0, 0, 32'h2, 0, 0, 4'd9); tick();
        idle(); tick();
        chk("pre-reset cal", cal_signal, 1);
        #1 rst_in = 1;
        #1;
        chk("async reset cal", cal_signal, 0);
        chk("async reset full", rs_full, 0);
        model_reset();
        #1 rst_in = 0;
        repeat (3) tick();
        chk("post-reset no issue", cal_signal, 0);

        // ready ADD issues two edges after dispatch for one cycle
        disp(4'd4, 32'd5, 0, 0, 32'd7, 0, 0, 4'd3); tick();
        idle(); tick();
        chk("add cal", cal_signal, 1);
        chk("add opcode", opcode, 4);
        chk("add lhs", lhs, 5);
        chk("add rhs", rhs, 7);
        chk("add tag", tag, 3);
        tick();
        chk("add one cycle", cal_signal, 0);

        // wakeup from ALU bus
        disp(4'd5, 0, 1, 4'd2, 32'd3, 0, 0, 4'd6); tick();
        idle(); tick();
        chk("waiting no issue", cal_signal, 0);
        alu_done = 1; alu_tag = 2; alu_value = 32'h10; tick();
        idle(); tick();
        chk("alu wake cal", cal_signal, 1);
        chk("alu wake lhs", lhs, 32'h10);
        // wakeup from LSB bus
        disp(4'd5, 32'd8, 0, 0, 0, 1, 4'd4, 4'd7); tick();
        idle(); tick();
        lsb_done = 1; lsb_tag = 4; lsb_value = 32'h20; tick();
        idle(); tick();
        chk("lsb wake cal", cal_signal, 1);
        chk("lsb wake rhs", rhs, 32'h20);
        // broadcast in the dispatch cycle
        disp(4'd5, 0, 1, 4'd9, 32'd1, 0, 0, 4'd8);
        alu_done = 1; alu_tag = 9; alu_value = 32'h30; tick();
        idle(); tick();
        chk("snoop cal", cal_signal, 1);
        chk("snoop lhs", lhs, 32'h30);
        tick();

        // fill, drop on full, wake one
        for (int k = 0; k < 8; k++) begin
            disp(4'd2, 0, 1, 4'(k), 32'(k), 0, 0, 4'(k)); tick();
        end
        chk("full", rs_full, 1);
        disp(4'd3, 32'hdead, 0, 0, 32'hbeef, 0, 0, 4'd15); tick();
        idle();
        chk("still full", rs_full, 1);
        chk("full no issue", cal_signal, 0);
        alu_done = 1; alu_tag = 5; alu_value = 32'h55; tick();
        idle(); tick();
        chk("full wake cal", cal_signal, 1);
        chk("full wake lhs", lhs, 32'h55);
        chk("full wake tag", tag, 5);
        chk("full drops", rs_full, 0);
        tick();
        chk("dropped op absent", cal_signal, 0);

        // clear beats pending issue and same-cycle dispatch
        disp(4'd2, 32'haa, 0, 0, 32'hbb, 0, 0, 4'd9); tick();
        disp(4'd6, 32'hcc, 0, 0, 32'hdd, 0, 0, 4'd10);
        clear_signal = 1; tick();
        idle();
        chk("clear cal", cal_signal, 0);
        chk("clear full", rs_full, 0);
        alu_done = 1; alu_tag = 0; alu_value = 32'h1; tick();
        idle(); repeat (2) tick();
        chk("cleared empty", cal_signal, 0);

        // rdy_in low freezes state and ignores broadcasts
        disp(4'd1, 0, 1, 4'd3, 32'd5, 0, 0, 4'd1); tick();
        disp(4'd7, 32'h11, 0, 0, 32'h22, 0, 0, 4'd2); tick();
        idle(); tick();
        chk("frz pre cal", cal_signal, 1);
        rdy_in = 0; alu_done = 1; alu_tag = 3; alu_value = 32'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz cal", cal_signal, 1);
            chk("frz lhs", lhs, 32'h11);
        end
        idle(); tick();
        chk("frz no capture", cal_signal, 0);
        alu_done = 1; alu_tag = 3; alu_value = 32'h99; tick();
        idle(); tick();
        chk("frz late wake", cal_signal, 1);
        chk("frz late lhs", lhs, 32'h99);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rdy_in = $urandom_range(9) != 0;
            clear_signal = $urandom_range(39) == 0;
            issue_valid = $urandom_range(2) != 0;
            issue_opcode = 4'($urandom);
            issue_vj = $urandom; issue_vk = $urandom;
            issue_qj_valid = $urandom_range(1); issue_qk_valid = $urandom_range(1);
            issue_qj = 4'($urandom_range(5)); issue_qk = 4'($urandom_range(5));
            issue_tag = 4'($urandom);
            alu_done = $urandom_range(1); alu_tag = 4'($urandom_range(5)); alu_value = $urandom;
            lsb_done = $urandom_range(1); lsb_tag = 4'($urandom_range(5)); lsb_value = $urandom;
            if (alu_done && lsb_done && alu_tag == lsb_tag) lsb_tag = 4'((alu_tag + 1) % 6);
            tick();
        end
        idle();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
